// File: rtl/qrow_demux_writer_if.sv
// Bundle of signals for one 16-entry Q-value row writer.
// Handshake: a request transfers on any rising clk edge where wr_valid and
// wr_ready are both high; wr_ready depends only on the writer's state, never
// on wr_valid, and a requester that sees wr_ready low must hold wr_valid and
// its payload (wr_sel, wr_mode, wr_data) stable until the transfer edge.
interface qrow_demux_writer_if #(
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_sel;
  logic              wr_mode;
  logic [DATA_W-1:0] wr_data;
  logic              clear_start;
  logic              busy;
  logic              wr_done;
  logic              sat_flag;
  logic              state_dbg;
  logic [DATA_W-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [DATA_W-1:0] q8, q9, q10, q11, q12, q13, q14, q15;

  modport master (
    output wr_valid, wr_sel, wr_mode, wr_data, clear_start,
    input  wr_ready, busy, wr_done, sat_flag, state_dbg,
    input  q0, q1, q2, q3, q4, q5, q6, q7,
    input  q8, q9, q10, q11, q12, q13, q14, q15
  );

  modport slave (
    input  wr_valid, wr_sel, wr_mode, wr_data, clear_start,
    output wr_ready, busy, wr_done, sat_flag, state_dbg,
    output q0, q1, q2, q3, q4, q5, q6, q7,
    output q8, q9, q10, q11, q12, q13, q14, q15
  );
endinterface

// File: rtl/qrow_demux_writer.sv
// Write side of the Q-value row: holds 16 signed entries, routes each write
// to the selected entry (overwrite or saturating accumulate) and runs a
// one-entry-per-cycle row clear. q0..q15 feed the read mux directly.
module qrow_demux_writer #(
  parameter int              DATA_W    = 16,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  qrow_demux_writer_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [DATA_W-1:0] Q_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state;
  logic [3:0]        clr_idx;
  logic [DATA_W-1:0] q_r [16];
  logic              busy_r;
  logic              wr_done_r;
  logic              sat_flag_r;

  logic [DATA_W-1:0]   cur;
  logic signed [DATA_W:0] sum;
  logic [DATA_W-1:0]   nxt;
  logic                nxt_sat;

  // New value for the selected entry: overwrite, or sign-extended sum clamped
  // to the representable range when the extra sum bit disagrees with the MSB.
  always_comb begin
    cur     = q_r[bus.wr_sel];
    sum     = $signed({cur[DATA_W-1], cur}) + $signed({bus.wr_data[DATA_W-1], bus.wr_data});
    nxt     = bus.wr_data;
    nxt_sat = 1'b0;
    if (bus.wr_mode) begin
      if (sum[DATA_W] != sum[DATA_W-1]) begin
        nxt_sat = 1'b1;
        nxt     = sum[DATA_W] ? Q_MIN : Q_MAX;
      end else begin
        nxt = sum[DATA_W-1:0];
      end
    end
  end

  // Control FSM, entry storage and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clr_idx    <= 4'd0;
      busy_r     <= 1'b0;
      wr_done_r  <= 1'b0;
      sat_flag_r <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        q_r[i] <= '0;
      end
    end else begin
      wr_done_r  <= 1'b0;
      sat_flag_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_valid) begin
            q_r[bus.wr_sel] <= nxt;
            wr_done_r       <= 1'b1;
            sat_flag_r      <= nxt_sat;
          end
          // A write in the same cycle still commits; the clear later overwrites it.
          if (bus.clear_start) begin
            state   <= CLEAR;
            busy_r  <= 1'b1;
            clr_idx <= 4'd0;
          end
        end
        CLEAR: begin
          q_r[clr_idx] <= CLEAR_VAL;
          if (clr_idx == 4'd15) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            clr_idx <= 4'd0;
          end else begin
            clr_idx <= clr_idx + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready  = (state == IDLE);
  assign bus.state_dbg = (state == CLEAR);
  assign bus.busy      = busy_r;
  assign bus.wr_done   = wr_done_r;
  assign bus.sat_flag  = sat_flag_r;

  assign bus.q0  = q_r[0];
  assign bus.q1  = q_r[1];
  assign bus.q2  = q_r[2];
  assign bus.q3  = q_r[3];
  assign bus.q4  = q_r[4];
  assign bus.q5  = q_r[5];
  assign bus.q6  = q_r[6];
  assign bus.q7  = q_r[7];
  assign bus.q8  = q_r[8];
  assign bus.q9  = q_r[9];
  assign bus.q10 = q_r[10];
  assign bus.q11 = q_r[11];
  assign bus.q12 = q_r[12];
  assign bus.q13 = q_r[13];
  assign bus.q14 = q_r[14];
  assign bus.q15 = q_r[15];

endmodule

// File: doc/qrow_demux_writer.md
Name: qrow_demux_writer

Overview:
- Write-side counterpart of the 16-to-1 Q-value read mux in the maze solver.
- Holds one 16-entry row of signed Q-values and routes each write request to the entry named by a 4-bit select.
- Supports plain overwrite or saturating accumulate, plus a sequenced row clear.
- Its q0..q15 outputs drive the d0..d15 inputs of the read mux directly.

Parameters:
- DATA_W, 16, width of each Q-value entry (two's complement signed).
- CLEAR_VAL, 0, value loaded into every entry by the clear sequence.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- wr_valid, input, 1, write request valid.
- wr_ready, output, 1, block can accept a request this cycle.
- wr_sel, input, 4, target entry index 0..15.
- wr_mode, input, 1, 0 = overwrite, 1 = saturating accumulate.
- wr_data, input, DATA_W, overwrite value, or signed delta in accumulate mode.
- clear_start, input, 1, starts the row clear sequence.
- busy, output, 1, high while clearing.
- wr_done, output, 1, one-cycle pulse after a committed write.
- sat_flag, output, 1, one-cycle pulse when an accumulate saturated.
- q0..q15, output, DATA_W each, registered entry contents.

Behaviour:
- Reset (async, rst=1): q0..q15=0, state=IDLE, busy=0, wr_done=0, sat_flag=0, wr_ready=1, clear index=0.
- Reset asserted mid-clear or mid-write aborts the operation immediately to the reset values above.
- wr_ready = (state==IDLE); combinational from the state register only, never from wr_valid.
- States: IDLE and CLEAR.
- IDLE accept: wr_valid & wr_ready at a rising edge commits the request at that same edge.
  - q[wr_sel] shows the new value in the following cycle.
  - wr_done is high for exactly that following cycle.
  - Write latency is 1 cycle.
- Overwrite: q[wr_sel] <= wr_data.
- Accumulate: compute q[wr_sel] + wr_data as a DATA_W+1-bit signed sum.
  - Above 2^(DATA_W-1)-1: clamp to that value (32767) and pulse sat_flag alongside wr_done.
  - Below -2^(DATA_W-1): clamp to that value (-32768) and pulse sat_flag alongside wr_done.
  - Otherwise store the sum unchanged; sat_flag stays 0.
- Only the selected entry changes; the other 15 entries hold.
- Back-to-back writes are accepted one per cycle with no bubble.
- Accumulates to the same entry on consecutive cycles chain correctly, because each uses the registered q value already updated at the prior edge.
- IDLE -> CLEAR: clear_start=1 in IDLE. The next cycle has busy=1 and wr_ready=0.
- CLEAR sequence:
  - One entry per cycle: q[idx] <= CLEAR_VAL, idx increments 0..15.
  - After idx 15 is written, return to IDLE and reset idx to 0.
  - busy is high for exactly 16 cycles.
  - wr_ready returns to 1 in the cycle after the last clear write.
- clear_start while in CLEAR is ignored; the sequence neither restarts nor extends.
- wr_valid while in CLEAR is not accepted; the requester must hold it until wr_ready=1.
- Simultaneous wr_valid and clear_start in IDLE: the write commits at that edge (wr_done pulses), then CLEAR begins. The write is therefore overwritten when its entry index is reached.
- wr_done and sat_flag never assert in CLEAR, except the wr_done pulse carried from the simultaneous case in the first CLEAR cycle.

Test Plan:
- Reset, then overwrite wr_sel=5, data=0x1234 -> next cycle q5=0x1234, wr_done=1 for 1 cycle, all other q=0.
- Overwrite q3=100, then accumulate wr_sel=3, data=-30 -> q3=70, sat_flag=0; then accumulate +32767 -> q3=32767, sat_flag=1.
- Overwrite q9=-32760, accumulate -100 -> q9=-32768, sat_flag=1; accumulate +5 on two consecutive cycles -> q9=-32763 then -32758.
- Fill all 16 entries with 0x00FF, pulse clear_start -> busy=1 for exactly 16 cycles; q0 clears first and q15 last; all entries 0; wr_ready returns to 1.
- Hold wr_valid (sel=2, data=7) through a clear -> no accept until busy falls; q2=7 one cycle after wr_ready rises; clear_start pulsed mid-clear -> sequence length still 16.
- Same cycle wr_valid (sel=0, data=9) and clear_start -> wr_done pulses, q0=9 for one cycle, then 0 after first clear cycle; assert rst mid-clear -> all outputs at reset values immediately.
